conv_window_buffer: RTL
=======================

# conv_window_buffer

Streaming 3x3 sliding-window generator that sits directly upstream of `convolution_engine`. It accepts a raster-order pixel stream, one pixel per handshake, and stores the two previous image rows in line buffers. For every pixel that completes a full 3x3 neighbourhood, it emits one registered 9-pixel window. Valid/ready handshakes are used on both sides, and downstream backpressure propagates to the pixel source.

## Interface
- `DATA_W`, 8, pixel width in bits
- `IMG_W`, 8, pixels per row (≥3)
- `IMG_H`, 8, rows per frame (≥3)
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  pixel present
- `in_ready`  out  1  block can accept pixel this cycle
- `in_sof`  in  1  qualifies pixel as frame position (0,0)
- `in_pix`  in  DATA_W  pixel data
- `out_valid`  out  1  window present
- `out_ready`  in  1  consumer accepts window
- `out_win`  out  9*DATA_W  window; tap (r,c) at bits [(3r+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 oldest column; tap (2,2) is the newest pixel
- `out_last`  out  1  window is the final one of the frame
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept occurs when `in_valid && in_ready`; `in_ready = !out_valid || out_ready`. This is a single output register with pass-through refill on the same cycle.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the accepted pixel. `in_sof` forces the position to (0,0) for that pixel, whatever the counter state.
- On accept at `col`:
  - read taps t1=`lb0[col]` (row-1) and t2=`lb1[col]` (row-2)
  - write `lb1[col]<=lb0[col]`, then `lb0[col]<=in_pix`
  - shift the window columns left and insert new column {t2, t1, in_pix}
- Window emit: when the accepted pixel has row≥2 and col≥2, load `out_win` with the shifted window and set `out_valid`. Set `out_last` when row==IMG_H-1 and col==IMG_W-1.
- Counter update: `col` wraps to 0 at IMG_W-1 and increments `row`. After row IMG_H-1 / col IMG_W-1, both wrap to 0 and `frame_done` pulses.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No padding, no edge windows.
- Line-buffer and shift-column contents are not reset. Emission gating alone guarantees that stale data is never emitted.
- `in_sof` mid-frame: the frame restarts at (0,0). No window is emitted until row≥2 and col≥2 of the new frame. `frame_done` does not pulse for the abandoned frame.

## Timing
- Latency: a window appears on `out_*` the cycle after its completing pixel is accepted.
- Throughput: one pixel and one window per cycle when `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, `in_ready`=0. `out_win` and `out_last` hold stable, and no counter or buffer state changes.
- `out_valid` clears on handshake unless a new window loads in the same cycle.
- Reset (asynchronous, any time):
  - outputs: `out_valid`=0, `out_win`=0, `out_last`=0, `frame_done`=0
  - `in_ready`=1 after reset deassertion
  - counters: `col`=`row`=0
  - an in-flight window is dropped

## Structure
- Shared package `conv_pkg`: `DATA_W` default, `KSIZE`=3, a window tap-index function (r,c)→bit offset, and the `pix_t` typedef. Reused by `convolution_engine`.
- Sub-module `conv_line_buffer`: IMG_W×DATA_W row memory with one indexed read/write port and enable. Instantiated twice (`lb0`, `lb1`).
- Top-level module: counters, column shift registers, output register, handshake logic.

## Test plan
- IMG_W=IMG_H=4, pixels 0..15, `in_sof` on pixel 0, `out_ready`=1:
  - exactly 4 windows
  - first window `out_win` taps = 0,1,2,4,5,6,8,9,10, one cycle after pixel 10 is accepted
  - last window = 5,6,7,9,10,11,13,14,15 with `out_last`=1
  - `frame_done` pulses after pixel 15
- Same stream with `out_ready`=0 for 5 cycles after the first window:
  - `in_ready`=0 throughout, first window held bit-stable
  - on release, all 4 windows arrive in order with no loss or duplication
- Two back-to-back frames (second uses pixels 100..115): second frame's first window = 100,101,102,104,105,106,108,109,110, with no frame-1 pixels present.
- `in_sof` asserted at pixel 6 of a frame: no window until 10 more pixels have been accepted from the new origin. The first window then matches the new frame only.
- Assert `rst_n`=0 while `out_valid`=1 and stalled:
  - outputs go to 0 asynchronously
  - after release, a fresh frame yields the correct 4 windows
- `in_valid` toggled randomly at 50%: the window sequence is identical to the continuous-stream case.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel type, kernel size and
// the packed-window tap layout used by the window buffer and the engine.
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int KSIZE      = 3;

    typedef logic [DEF_DATA_W-1:0] pix_t;

    // Bit offset of tap (r,c) in a packed KSIZE x KSIZE window; r=0 is the oldest row.
    function automatic int tap_off(input int r, input int c, input int w);
        return (KSIZE * r + c) * w;
    endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out stream bundle for conv_window_buffer. The slave side is
// the window buffer; the master side is the pixel source and window consumer.
interface conv_window_buffer_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_sof;
    logic [DATA_W-1:0]               in_pix;
    logic                            out_valid;
    logic                            out_ready;
    logic [KSIZE*KSIZE*DATA_W-1:0]   out_win;
    logic                            out_last;
    logic                            frame_done;

    modport master (
        output in_valid, in_sof, in_pix, out_ready,
        input  in_ready, out_valid, out_win, out_last, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pix, out_ready,
        output in_ready, out_valid, out_win, out_last, frame_done
    );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage with a single indexed port: combinational
// read of the old contents and a clocked write of the new value at the same index.
module conv_line_buffer #(
    parameter int DATA_W = conv_pkg::DEF_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // NOTE: storage arrays carry no reset; emission gating upstream keeps stale
    // contents from ever reaching an output, and a reset here would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming 3x3 sliding-window generator: two line buffers plus two column
// shift registers form each window, presented through one registered output stage.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    conv_window_buffer_if.slave bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int WIN_W = KSIZE * KSIZE * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KSIZE - 1);

    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [ROW_W-1:0]  row_q, row_d, row_cur;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic [WIN_W-1:0]  out_win_q, out_win_d, win_next;
    logic [DATA_W-1:0] tap_r1, tap_r2;
    logic [DATA_W-1:0] sh0_q [KSIZE];
    logic [DATA_W-1:0] sh0_d [KSIZE];
    logic [DATA_W-1:0] sh1_q [KSIZE];
    logic [DATA_W-1:0] sh1_d [KSIZE];
    logic [DATA_W-1:0] new_col [KSIZE];
    logic              in_ready, accept, emit, pos_last;

    // Single output register with same-cycle refill: a consumed window frees the slot.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign col_cur  = bus.in_sof ? '0 : col_q;
    assign row_cur  = bus.in_sof ? '0 : row_q;
    assign pos_last = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
    assign emit     = accept && (col_cur >= COL_WIN) && (row_cur >= ROW_WIN);

    assign new_col[0] = tap_r2;
    assign new_col[1] = tap_r1;
    assign new_col[2] = bus.in_pix;

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_cur),
        .wr_data (bus.in_pix),
        .rd_data (tap_r1)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_cur),
        .wr_data (tap_r1),
        .rd_data (tap_r2)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < KSIZE; r++) begin
            win_next[tap_off(r, 0, DATA_W) +: DATA_W] = sh0_q[r];
            win_next[tap_off(r, 1, DATA_W) +: DATA_W] = sh1_q[r];
            win_next[tap_off(r, 2, DATA_W) +: DATA_W] = new_col[r];
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_win_d    = out_win_q;
        out_last_d   = out_last_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        sh0_d        = sh0_q;
        sh1_d        = sh1_q;

        if (emit) begin
            out_valid_d = 1'b1;
            out_win_d   = win_next;
            out_last_d  = pos_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            sh0_d = sh1_q;
            sh1_d = new_col;
            if (col_cur == COL_LAST) begin
                col_d = '0;
                if (row_cur == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_cur + ROW_W'(1);
                end
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
        end
    end

    // NOTE: sequential state updates use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_win_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_win_q    <= out_win_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        sh0_q <= sh0_d;
        sh1_q <= sh1_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_win    = out_win_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;

endmodule
